// File: rtl/partition_err_sweep_pkg.sv
// Shared types and width helpers for the partition error sweep.
//   state_e      : sweep controller states
//   hd_width     : bits needed for one Hamming distance of an n_out-bit word
//   cnt_width    : error-count accumulator width (one more bit than the index)
//   hd_sum_width : Hamming-distance accumulator width
//   ed_sum_width : absolute-difference accumulator width
package partition_err_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic int unsigned hd_width(input int unsigned n_out);
    return $clog2(n_out + 1);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n_in);
    return n_in + 1;
  endfunction

  function automatic int unsigned hd_sum_width(input int unsigned n_in, input int unsigned n_out);
    return n_in + hd_width(n_out);
  endfunction

  function automatic int unsigned ed_sum_width(input int unsigned n_in, input int unsigned n_out);
    return n_in + n_out;
  endfunction

endpackage

// File: rtl/partition_err_sweep_err_metric.sv
// Combinational distance between an exact and an approximate result word.
//   exact_i  : exact result
//   approx_i : approximate result
//   hd_o     : Hamming distance (popcount of exact ^ approx)
//   ed_o     : |exact - approx|, unsigned
//   neq_o    : words differ
module err_metric
  import partition_err_sweep_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0]           exact_i,
  input  logic [W-1:0]           approx_i,
  output logic [hd_width(W)-1:0] hd_o,
  output logic [W-1:0]           ed_o,
  output logic                   neq_o
);

  localparam int unsigned HD_W = hd_width(W);
  typedef logic [HD_W-1:0] hd_t;

  logic [W-1:0] diff;

  always_comb begin
    diff = exact_i ^ approx_i;
    hd_o = '0;
    for (int unsigned i = 0; i < W; i++) begin
      hd_o = hd_o + hd_t'(diff[i]);
    end
    ed_o  = (exact_i >= approx_i) ? (exact_i - approx_i) : (approx_i - exact_i);
    neq_o = |diff;
  end

endmodule

// File: rtl/partition_err_sweep.sv
// Exhaustive error sweep of a factorized partition against its exact sub-block.
// Issues every input pattern once, compares exact_i/approx_i one cycle later
// and accumulates error count, Hamming-distance sum, |difference| sum and the
// maximum |difference|.
//   clk, rst            : clock, synchronous active-high reset
//   start_i             : start a sweep (accepted only in IDLE)
//   hold_i              : stall the sweep while high
//   vec_o, vec_valid_o  : issued pattern and its valid strobe
//   exact_i, approx_i   : results for vec_o, same cycle
//   busy_o, done_o      : sweep in progress / one-cycle completion pulse
//   err_cnt_o, hd_sum_o, ed_sum_o, max_ed_o : accumulated results
module partition_err_sweep
  import partition_err_sweep_pkg::*;
#(
  parameter int unsigned N_IN  = 7,
  parameter int unsigned N_OUT = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start_i,
  input  logic                                  hold_i,
  output logic [N_IN-1:0]                       vec_o,
  output logic                                  vec_valid_o,
  input  logic [N_OUT-1:0]                      exact_i,
  input  logic [N_OUT-1:0]                      approx_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic [cnt_width(N_IN)-1:0]            err_cnt_o,
  output logic [hd_sum_width(N_IN, N_OUT)-1:0]  hd_sum_o,
  output logic [ed_sum_width(N_IN, N_OUT)-1:0]  ed_sum_o,
  output logic [N_OUT-1:0]                      max_ed_o
);

  localparam int unsigned HD_W  = hd_width(N_OUT);
  localparam int unsigned CNT_W = cnt_width(N_IN);
  localparam int unsigned HDS_W = hd_sum_width(N_IN, N_OUT);
  localparam int unsigned EDS_W = ed_sum_width(N_IN, N_OUT);

  typedef logic [N_IN-1:0]  idx_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [HDS_W-1:0] hds_t;
  typedef logic [EDS_W-1:0] eds_t;

  state_e             state_q, state_d;
  idx_t               idx_q, idx_d;
  logic               stg_valid_q, stg_valid_d;
  logic [N_OUT-1:0]   stg_exact_q, stg_exact_d;
  logic [N_OUT-1:0]   stg_approx_q, stg_approx_d;
  cnt_t               err_cnt_q, err_cnt_d;
  hds_t               hd_sum_q, hd_sum_d;
  eds_t               ed_sum_q, ed_sum_d;
  logic [N_OUT-1:0]   max_ed_q, max_ed_d;

  logic [HD_W-1:0]    m_hd;
  logic [N_OUT-1:0]   m_ed;
  logic               m_neq;

  err_metric #(
    .W(N_OUT)
  ) u_err_metric (
    .exact_i  (stg_exact_q),
    .approx_i (stg_approx_q),
    .hd_o     (m_hd),
    .ed_o     (m_ed),
    .neq_o    (m_neq)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    stg_valid_d  = 1'b0;
    stg_exact_d  = stg_exact_q;
    stg_approx_d = stg_approx_q;
    err_cnt_d    = err_cnt_q;
    hd_sum_d     = hd_sum_q;
    ed_sum_d     = ed_sum_q;
    max_ed_d     = max_ed_q;
    vec_valid_o  = 1'b0;

    // Accumulate stage runs independently of the controller so the last
    // captured vector is folded in during DRAIN.
    if (stg_valid_q) begin
      err_cnt_d = err_cnt_q + cnt_t'(m_neq);
      hd_sum_d  = hd_sum_q + hds_t'(m_hd);
      ed_sum_d  = ed_sum_q + eds_t'(m_ed);
      if (m_ed > max_ed_q) begin
        max_ed_d = m_ed;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d   = ST_SWEEP;
          idx_d     = '0;
          err_cnt_d = '0;
          hd_sum_d  = '0;
          ed_sum_d  = '0;
          max_ed_d  = '0;
        end
      end
      ST_SWEEP: begin
        if (!hold_i) begin
          vec_valid_o  = 1'b1;
          stg_valid_d  = 1'b1;
          stg_exact_d  = exact_i;
          stg_approx_d = approx_i;
          // Last pattern parks the index instead of wrapping.
          if (idx_q == '1) begin
            state_d = ST_DRAIN;
          end else begin
            idx_d = idx_q + idx_t'(1);
          end
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      stg_valid_q  <= 1'b0;
      stg_exact_q  <= '0;
      stg_approx_q <= '0;
      err_cnt_q    <= '0;
      hd_sum_q     <= '0;
      ed_sum_q     <= '0;
      max_ed_q     <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      stg_valid_q  <= stg_valid_d;
      stg_exact_q  <= stg_exact_d;
      stg_approx_q <= stg_approx_d;
      err_cnt_q    <= err_cnt_d;
      hd_sum_q     <= hd_sum_d;
      ed_sum_q     <= ed_sum_d;
      max_ed_q     <= max_ed_d;
    end
  end

  assign vec_o     = idx_q;
  assign busy_o    = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
  assign done_o    = (state_q == ST_DONE);
  assign err_cnt_o = err_cnt_q;
  assign hd_sum_o  = hd_sum_q;
  assign ed_sum_o  = ed_sum_q;
  assign max_ed_o  = max_ed_q;

endmodule

// File: tb/tb_partition_err_sweep.sv
// Directed bench for partition_err_sweep with default parameters (7 in, 4 out).
module tb_partition_err_sweep;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        hold_i;
  logic [6:0]  vec_o;
  logic        vec_valid_o;
  logic [3:0]  exact_i;
  logic [3:0]  approx_i;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  err_cnt_o;
  logic [9:0]  hd_sum_o;
  logic [10:0] ed_sum_o;
  logic [3:0]  max_ed_o;

  int checks = 0;
  int errors = 0;
  int mode   = 0;
  int mon_next, mon_bad, mon_issued, mon_done;
  int done_at;

  partition_err_sweep #(
    .N_IN  (7),
    .N_OUT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .hold_i      (hold_i),
    .vec_o       (vec_o),
    .vec_valid_o (vec_valid_o),
    .exact_i     (exact_i),
    .approx_i    (approx_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_cnt_o   (err_cnt_o),
    .hd_sum_o    (hd_sum_o),
    .ed_sum_o    (ed_sum_o),
    .max_ed_o    (max_ed_o)
  );

  always #5 clk = ~clk;

  // Partition models driven from the issued pattern.
  always_comb begin
    exact_i  = vec_o[3:0] ^ {1'b0, vec_o[6:4]};
    approx_i = exact_i;
    case (mode)
      1: begin exact_i = 4'hF; approx_i = 4'h0; end
      2: approx_i = (vec_o == 7'h7F) ? (exact_i ^ 4'b0001) : exact_i;
      3: begin exact_i = 4'h8; approx_i = (vec_o[6:5] == 2'b11) ? 4'h1 : 4'h8; end
      4: begin exact_i = 4'h1; approx_i = (vec_o == 7'h00) ? 4'hC : 4'h1; end
      default: ;
    endcase
  end

  always @(negedge clk) begin
    if (vec_valid_o) begin
      if (vec_o !== mon_next[6:0]) mon_bad++;
      mon_next++;
      mon_issued++;
    end
    if (done_o) mon_done++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    mon_next = 0; mon_bad = 0; mon_issued = 0; mon_done = 0;
  endtask

  // Cycle n = number of edges after the edge that sampled start_i.
  task automatic run_sweep(input int m, input int hlo, input int hhi, input int s2, output int d_at);
    int n;
    mode = m;
    mon_clear();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 1;
    d_at = -1;
    while (n < 400) begin
      hold_i  = (n >= hlo) && (n < hhi);
      start_i = (n == s2);
      if (done_o) begin
        d_at = n;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    hold_i  = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic chk_totals(input string tag, input int ec, input int hs, input int es, input int mx);
    chk({tag, ".err_cnt"}, 32'(err_cnt_o), ec);
    chk({tag, ".hd_sum"},  32'(hd_sum_o),  hs);
    chk({tag, ".ed_sum"},  32'(ed_sum_o),  es);
    chk({tag, ".max_ed"},  32'(max_ed_o),  mx);
  endtask

  task automatic chk_after(input string tag);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, ".issued"},   mon_issued, 128);
    chk({tag, ".order"},    mon_bad,    0);
    chk({tag, ".done_cnt"}, mon_done,   1);
    chk({tag, ".busy_idle"}, 32'(busy_o), 0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; hold_i = 1'b0;
    mon_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy_o), 0);
    chk("rst.done", 32'(done_o), 0);
    chk("rst.vec_valid", 32'(vec_valid_o), 0);
    chk("rst.vec", 32'(vec_o), 0);
    chk_totals("rst", 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_sweep(0, -1, -1, -1, done_at);
    chk("match.done_at", done_at, 130);
    chk_totals("match", 0, 0, 0, 0);
    chk_after("match");

    run_sweep(1, -1, -1, -1, done_at);
    chk("allones.done_at", done_at, 130);
    chk_totals("allones", 128, 512, 1920, 15);
    chk_after("allones");
    chk_totals("allones_hold", 128, 512, 1920, 15);

    run_sweep(2, -1, -1, -1, done_at);
    chk("last.done_at", done_at, 130);
    chk_totals("last", 1, 1, 1, 1);
    chk_after("last");

    run_sweep(3, -1, -1, -1, done_at);
    chk("quarter.done_at", done_at, 130);
    chk_totals("quarter", 32, 64, 224, 7);
    chk_after("quarter");

    run_sweep(4, -1, -1, -1, done_at);
    chk("first.done_at", done_at, 130);
    chk_totals("first", 1, 3, 11, 11);
    chk_after("first");

    run_sweep(3, 60, 70, -1, done_at);
    chk("hold.done_at", done_at, 140);
    chk_totals("hold", 32, 64, 224, 7);
    chk_after("hold");

    run_sweep(1, 129, 131, -1, done_at);
    chk("drainhold.done_at", done_at, 130);
    chk_totals("drainhold", 128, 512, 1920, 15);
    chk_after("drainhold");

    run_sweep(2, -1, -1, 50, done_at);
    chk("restart.done_at", done_at, 130);
    chk_totals("restart", 1, 1, 1, 1);
    chk_after("restart");

    // Reset in cycle 60 of a sweep.
    mode = 1;
    mon_clear();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (59) @(posedge clk);
    #1;
    chk("midrst.busy_before", 32'(busy_o), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst.busy", 32'(busy_o), 0);
    chk("midrst.done", 32'(done_o), 0);
    chk("midrst.vec_valid", 32'(vec_valid_o), 0);
    chk("midrst.vec", 32'(vec_o), 0);
    chk_totals("midrst", 0, 0, 0, 0);
    repeat (150) @(posedge clk);
    #1;
    chk("midrst.no_done", mon_done, 0);

    run_sweep(1, -1, -1, -1, done_at);
    chk("fresh.done_at", done_at, 130);
    chk_totals("fresh", 128, 512, 1920, 15);
    chk_after("fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/partition_err_sweep.md
PARTITION_ERR_SWEEP -- requirements
Module: partition_err_sweep

Interface
REQ-001 SHALL have parameter N_IN, default 7: width of the partition input vector (pi0 = LSB).
REQ-002 SHALL have parameter N_OUT, default 4: width of the partition output vector (po0 = LSB).
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start_i, input, 1: begins an exhaustive sweep when sampled high in IDLE.
REQ-006 SHALL have port hold_i, input, 1: stalls the sweep for the cycles it is high.
REQ-007 SHALL have port vec_o, output, N_IN: pattern driven onto the partition inputs.
REQ-008 SHALL have port vec_valid_o, output, 1: vec_o is issued this cycle.
REQ-009 SHALL have port exact_i, input, N_OUT: exact sub-block result for vec_o, same cycle.
REQ-010 SHALL have port approx_i, input, N_OUT: approximate (factorized) partition result for vec_o, same cycle.
REQ-011 SHALL have port busy_o, output, 1: high in SWEEP and DRAIN.
REQ-012 SHALL have port done_o, output, 1: single-cycle completion pulse.
REQ-013 SHALL have port err_cnt_o, output, N_IN+1: count of vectors with exact != approx.
REQ-014 SHALL have port hd_sum_o, output, N_IN+clog2(N_OUT+1): sum of Hamming distances.
REQ-015 SHALL have port ed_sum_o, output, N_IN+N_OUT: sum of |exact - approx| (unsigned).
REQ-016 SHALL have port max_ed_o, output, N_OUT: maximum |exact - approx| seen.

Function
REQ-017 SHALL implement FSM IDLE -> SWEEP -> DRAIN -> DONE -> IDLE.
REQ-018 IDLE: start_i high SHALL clear all four accumulators and the index, and enter SWEEP.
REQ-019 SWEEP, hold_i low: SHALL drive vec_valid_o=1 and vec_o=index, capture {exact_i, approx_i} into a stage register with a valid bit, and increment the index.
REQ-020 SWEEP, hold_i high: SHALL drive vec_valid_o=0, hold the index, and capture nothing (stage valid=0).
REQ-021 Issuing index 2^N_IN-1 SHALL move the FSM to DRAIN. The index SHALL NOT wrap into a second pass.
REQ-022 Accumulate stage: SHALL update all accumulators one cycle after capture, only when stage valid=1.
REQ-023 DRAIN SHALL last exactly one cycle. hold_i SHALL be ignored in DRAIN.
REQ-024 DONE SHALL assert done_o for one cycle, then return to IDLE.
REQ-025 Without hold, done_o SHALL be high exactly 130 cycles after the start_i cycle (N_IN=7).
REQ-026 Result outputs SHALL be final when done_o is high and SHALL hold until the next accepted start_i.
REQ-027 start_i in SWEEP, DRAIN or DONE SHALL be ignored.
REQ-028 Accumulator widths SHALL be sized so that no overflow occurs at the worst case (all-ones error).

Reset
REQ-029 rst SHALL force IDLE, index=0, stage valid=0, vec_valid_o=0, busy_o=0, done_o=0, and all result outputs=0 on the next edge.
REQ-030 rst SHALL take priority over start_i and hold_i. A sweep interrupted by rst SHALL be discarded, with no done_o pulse.

Structure
REQ-031 A shared package SHALL hold the FSM state enum and the width-derivation constants/functions.
REQ-032 The distance computation (popcount of XOR, absolute difference) SHALL be one combinational sub-module, err_metric, instantiated once.

Verification
REQ-033 approx_i tied to exact_i -> all results 0, done_o at cycle 130, vec_o = 0..127 in order.
REQ-034 exact_i=4'hF, approx_i=4'h0 throughout -> err_cnt=128, hd_sum=512, ed_sum=1920, max_ed=15.
REQ-035 approx_i = exact_i ^ 4'b0001 only when vec_o=7'h7F -> err_cnt=1, hd_sum=1, ed_sum=1, max_ed=1 (last-vector boundary).
REQ-036 hold_i high for 10 cycles mid-sweep -> done_o at cycle 140, same totals as without hold, no vec_o gaps or repeats.
REQ-037 rst at cycle 60 of a sweep -> next cycle busy_o=0, outputs=0, no done_o; a fresh start_i then yields correct full totals.
REQ-038 start_i pulsed at cycle 50 during SWEEP -> ignored; single done_o at cycle 130.
